// File: rtl/seq_shift_left.sv
// Multi-cycle 64-bit logical left shifter (SLL/SLLI/SLLW).
// Resolves one barrel stage per clock, giving a fixed six-cycle latency behind valid/ready ports.
module seq_shift_left #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] _shift,
  input  logic             word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned SW   = $clog2(STAGES);
  localparam int unsigned HALF = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      stage_q;
  logic [STAGES-1:0]  amt_q;
  logic               word_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   out_q;
  logic [WIDTH-1:0]   stage_res;
  logic [STAGES-1:0]  amt_in;
  logic               in_fire;
  logic               last_stage;
  logic               unused_shift_hi;

  assign unused_shift_hi = ^_shift[WIDTH-1:STAGES];

  assign in_fire    = in_valid && (state_q == IDLE);
  assign last_stage = (stage_q == SW'(STAGES - 1));
  assign amt_in     = word ? {1'b0, _shift[STAGES-2:0]} : _shift[STAGES-1:0];

  // Final stage doubles as the SLLW sign-extension step instead of the 32-bit shift.
  always_comb begin
    stage_res = work_q;
    if (last_stage) begin
      if (word_q)
        stage_res = {{HALF{work_q[HALF-1]}}, work_q[HALF-1:0]};
      else if (amt_q[STAGES-1])
        stage_res = work_q << HALF;
    end else if (amt_q[stage_q]) begin
      stage_res = work_q << (32'd1 << stage_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_fire) state_d = SHIFT;
      SHIFT:   if (last_stage) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      amt_q   <= '0;
      word_q  <= 1'b0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            work_q  <= data;
            amt_q   <= amt_in;
            word_q  <= word;
            stage_q <= '0;
          end
        end
        SHIFT: begin
          work_q <= stage_res;
          if (last_stage) begin
            stage_q <= '0;
            out_q   <= stage_res;
          end else begin
            stage_q <= stage_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT) || (state_q == DONE);
    out       = out_q;
  end

endmodule

// File: tb/tb_seq_shift_left.sv
// Directed-vector bench for seq_shift_left: latency, masking, word mode, backpressure and reset.
module tb_seq_shift_left;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = '0;
  logic [63:0] _shift = '0;
  logic        word = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seq_shift_left #(.WIDTH(64), .STAGES(6)) dut (
    .clk(clk), .rst(rst), .data(data), ._shift(_shift), .word(word),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Holds in_valid until the unit accepts; returns #1 after the accepting edge.
  task automatic issue(input logic [63:0] d, input logic [63:0] s, input logic w, output logic ok);
    data = d; _shift = s; word = w; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Counts edges from acceptance until out_valid; lat = -1 on timeout.
  task automatic await_result(output logic [63:0] res, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    res = out;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; data = 64'h1234; _shift = 64'd1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0; rst = 1'b0;
    checks++;
    if (out !== 64'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state out=%h out_valid=%b busy=%b in_ready=%b want 0/0/0/1",
               out, out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_in_valid busy=%b want 0", busy);
    end
  endtask

  task automatic test_vectors();
    logic [63:0] vd [8];
    logic [63:0] vs [8];
    logic        vw [8];
    logic [63:0] ve [8];
    logic [63:0] res;
    logic        ok;
    int          lat;
    vd[0] = 64'h0000000000000001; vs[0] = 64'd63; vw[0] = 1'b0; ve[0] = 64'h8000000000000000;
    vd[1] = 64'h8000000000000000; vs[1] = 64'd1;  vw[1] = 1'b0; ve[1] = 64'h0000000000000000;
    vd[2] = 64'h0000000000000001; vs[2] = 64'd65; vw[2] = 1'b0; ve[2] = 64'h0000000000000002;
    vd[3] = 64'hA0A0A0A0A0A0A0A0; vs[3] = 64'd0;  vw[3] = 1'b0; ve[3] = 64'hA0A0A0A0A0A0A0A0;
    vd[4] = 64'h0000000000000001; vs[4] = 64'd31; vw[4] = 1'b1; ve[4] = 64'hFFFFFFFF80000000;
    vd[5] = 64'h0000000000000001; vs[5] = 64'd37; vw[5] = 1'b1; ve[5] = 64'h0000000000000020;
    vd[6] = 64'h0000000080000000; vs[6] = 64'd0;  vw[6] = 1'b1; ve[6] = 64'hFFFFFFFF80000000;
    vd[7] = 64'h12345678FFFFFFFF; vs[7] = 64'd4;  vw[7] = 1'b1; ve[7] = 64'hFFFFFFFFFFFFFFF0;
    for (int i = 0; i < 8; i++) begin
      issue(vd[i], vs[i], vw[i], ok);
      await_result(res, lat);
      checks++;
      if (!ok || lat !== 6) begin
        errors++;
        $display("FAIL vec%0d_latency accepted=%b got %0d want 6", i, ok, lat);
      end
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d_out got %h want %h", i, res, ve[i]);
      end
      retire();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_retire out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res;
    logic        ok;
    int          lat;
    issue(64'h3, 64'd2, 1'b0, ok);
    await_result(res, lat);
    checks++;
    if (!ok || lat !== 6 || res !== 64'hC) begin
      errors++;
      $display("FAIL bp_first got %h lat %0d want 000000000000000c lat 6", res, lat);
    end
    data = 64'h5; _shift = 64'd1; word = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out !== 64'hC || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d out=%h out_valid=%b in_ready=%b busy=%b want c/1/0/1",
                 i, out, out_valid, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    issue(64'h5, 64'd1, 1'b0, ok);
    await_result(res, lat);
    checks++;
    if (!ok || lat !== 6 || res !== 64'hA) begin
      errors++;
      $display("FAIL bp_second got %h lat %0d want 000000000000000a lat 6", res, lat);
    end
    retire();
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] res;
    logic        ok;
    int          lat;
    issue(64'h1, 64'd63, 1'b0, ok);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out !== 64'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_op out=%h out_valid=%b busy=%b in_ready=%b want 0/0/0/1",
               out, out_valid, busy, in_ready);
    end
    issue(64'hF, 64'd4, 1'b0, ok);
    await_result(res, lat);
    checks++;
    if (!ok || lat !== 6 || res !== 64'hF0) begin
      errors++;
      $display("FAIL rst_mid_op_next got %h lat %0d want 00000000000000f0 lat 6", res, lat);
    end
    retire();
  endtask

  task automatic test_reset_in_done();
    logic [63:0] res;
    logic        ok;
    int          lat;
    issue(64'h3, 64'd2, 1'b0, ok);
    await_result(res, lat);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    checks++;
    if (out !== 64'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_done out=%h out_valid=%b busy=%b want 0/0/0", out, out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_op();
    test_reset_in_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
